// File: rtl/div_share_ctrl_pkg.sv
// Shared pipeline definitions for the dual-pipe divider controller.
// Holds the divide op encoding, default iteration count and sign helper.
package div_share_ctrl_pkg;

    localparam int unsigned DivCyclesDefault = 32;
    localparam int unsigned DataWidth        = 32;

    // bit1 = remainder result, bit0 = signed operands
    typedef struct packed {
        logic rem;
        logic sgn;
    } div_op_t;

    function automatic logic [DataWidth-1:0] cond_neg(input logic [DataWidth-1:0] v,
                                                      input logic                 neg);
        return neg ? (~v + DataWidth'(1)) : v;
    endfunction

endpackage

// File: rtl/div_share_ctrl_if.sv
// Request/response bundle between the two EX pipes and the shared divider.
// The master side is the pipeline, the slave side is div_share_ctrl.
interface div_share_ctrl_if;
    import div_share_ctrl_pkg::*;

    logic    [1:0]       req_valid_i;
    div_op_t [1:0]       req_op_i;
    logic    [1:0][31:0] req_a_i;
    logic    [1:0][31:0] req_b_i;
    logic                older_i;
    logic                advance_i;
    logic    [1:0]       clr_i;
    logic    [1:0]       stall_req_o;
    logic    [1:0]       resp_valid_o;
    logic    [1:0][31:0] resp_data_o;

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, older_i, advance_i, clr_i,
        input  stall_req_o, resp_valid_o, resp_data_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, older_i, advance_i, clr_i,
        output stall_req_o, resp_valid_o, resp_data_o
    );

endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done_o is high during the final iteration cycle; results are stable the cycle after.
module div_iter
    import div_share_ctrl_pkg::*;
#(
    parameter int unsigned DivCycles = DivCyclesDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [DataWidth-1:0] dividend_i,
    input  logic [DataWidth-1:0] divisor_i,
    output logic                 done_o,
    output logic [DataWidth-1:0] quot_o,
    output logic [DataWidth-1:0] rem_o
);

    localparam int unsigned        CntW    = (DivCycles > 1) ? $clog2(DivCycles) : 1;
    localparam logic [CntW-1:0]    CntLast = CntW'(DivCycles - 1);

    logic                 run_q,  run_d;
    logic [CntW-1:0]      cnt_q,  cnt_d;
    logic [DataWidth-1:0] quot_q, quot_d;
    logic [DataWidth-1:0] rem_q,  rem_d;
    logic [DataWidth-1:0] div_q,  div_d;

    logic [DataWidth:0]   shifted;
    logic [DataWidth:0]   trial;
    logic                 fits;

    // Partial remainder stays below the divisor, so the borrow bit alone decides the step.
    assign shifted = {rem_q, quot_q[DataWidth-1]};
    assign trial   = shifted - {1'b0, div_q};
    assign fits    = ~trial[DataWidth];
    assign done_o  = run_q && (cnt_q == CntLast);

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        div_d  = div_q;
        if (start_i) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            quot_d = dividend_i;
            rem_d  = '0;
            div_d  = divisor_i;
        end else if (abort_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (run_q) begin
            quot_d = {quot_q[DataWidth-2:0], fits};
            rem_d  = fits ? trial[DataWidth-1:0] : shifted[DataWidth-1:0];
            if (done_o) begin
                run_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider between two EX pipes: arbitration, sign fix-up,
// per-pipe result slots and flush handling.
module div_share_ctrl
    import div_share_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = DivCyclesDefault
) (
    input  logic                   clk,
    input  logic                   rst_n,
    div_share_ctrl_if.slave        ctrl_io
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q;
    logic                 owner_q;
    div_op_t              op_q;
    logic                 neg_a_q;
    logic                 neg_b_q;
    logic                 bzero_q;
    logic [1:0]           slot_valid_q;
    logic [1:0][31:0]     slot_data_q;

    logic [1:0]           eligible;
    logic                 grant;
    logic                 start;
    div_op_t              sel_op;
    logic [31:0]          sel_a;
    logic [31:0]          sel_b;
    logic                 sel_neg_a;
    logic                 sel_neg_b;
    logic                 owner_kill;
    logic                 iter_done;
    logic [31:0]          iter_quot;
    logic [31:0]          iter_rem;
    logic [31:0]          q_fix;
    logic [31:0]          r_fix;
    logic [31:0]          result;

    assign eligible = ctrl_io.req_valid_i & ~slot_valid_q & ~ctrl_io.clr_i
                      & {2{~ctrl_io.advance_i}};
    // Older pipe wins a tie; otherwise whichever pipe is eligible.
    assign grant    = eligible[1] & (~eligible[0] | ctrl_io.older_i);
    assign start    = (state_q == StIdle) && (|eligible);

    assign sel_op    = ctrl_io.req_op_i[grant];
    assign sel_a     = ctrl_io.req_a_i[grant];
    assign sel_b     = ctrl_io.req_b_i[grant];
    assign sel_neg_a = sel_op.sgn & sel_a[31];
    assign sel_neg_b = sel_op.sgn & sel_b[31];

    assign owner_kill = ctrl_io.clr_i[owner_q] | ctrl_io.advance_i;

    div_iter #(
        .DivCycles (DIV_CYCLES)
    ) u_div_iter (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .abort_i    ((state_q == StCalc) && owner_kill),
        .dividend_i (cond_neg(sel_a, sel_neg_a)),
        .divisor_i  (cond_neg(sel_b, sel_neg_b)),
        .done_o     (iter_done),
        .quot_o     (iter_quot),
        .rem_o      (iter_rem)
    );

    // Divide-by-zero leaves the dividend magnitude in the remainder, so only q needs forcing.
    assign q_fix  = bzero_q ? 32'hFFFF_FFFF
                            : cond_neg(iter_quot, op_q.sgn & (neg_a_q ^ neg_b_q));
    assign r_fix  = cond_neg(iter_rem, op_q.sgn & neg_a_q);
    assign result = op_q.rem ? r_fix : q_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            op_q         <= '0;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            bzero_q      <= 1'b0;
            slot_valid_q <= '0;
            slot_data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        owner_q <= grant;
                        op_q    <= sel_op;
                        neg_a_q <= sel_neg_a;
                        neg_b_q <= sel_neg_b;
                        bzero_q <= (sel_b == 32'd0);
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    if (owner_kill) begin
                        state_q <= StIdle;
                    end else if (iter_done) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    if (!owner_kill) begin
                        slot_valid_q[owner_q] <= 1'b1;
                        slot_data_q[owner_q]  <= result;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Placed last so a clear beats a same-cycle FIX write.
            for (int p = 0; p < 2; p++) begin
                if (ctrl_io.advance_i || ctrl_io.clr_i[p]) begin
                    slot_valid_q[p] <= 1'b0;
                end
            end
        end
    end

    assign ctrl_io.stall_req_o  = ctrl_io.req_valid_i & ~slot_valid_q;
    assign ctrl_io.resp_valid_o = slot_valid_q;
    assign ctrl_io.resp_data_o  = slot_data_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl: directed corner cases, random ops against
// an arithmetic reference, arbitration, flush and mid-operation reset.
module tb_div_share_ctrl;
    import div_share_ctrl_pkg::*;

    localparam int Lat = 34;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    div_share_ctrl_if ifc ();

    div_share_ctrl #(
        .DIV_CYCLES (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_io (ifc.slave)
    );

    // advance_i must never arrive while the divider is busy
    always @(negedge clk) begin
        if (rst_n && ifc.advance_i && (int'(dut.state_q) != 0)) begin
            $display("FAIL advance_while_busy: advance_i=1 with FSM busy, required idle");
            miscompares++;
        end
    end

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.req_valid_i = '0;
        ifc.req_op_i    = '0;
        ifc.req_a_i     = '0;
        ifc.req_b_i     = '0;
        ifc.older_i     = 1'b0;
        ifc.advance_i   = 1'b0;
        ifc.clr_i       = '0;
    endtask

    // Stimulus only: issue one op, wait for its slot, then retire it with advance_i.
    task automatic issue_and_wait(input int p, input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] op, output int lat,
                                  output logic [31:0] data, output logic valid_after);
        ifc.req_valid_i[p] = 1'b1;
        ifc.req_a_i[p]     = a;
        ifc.req_b_i[p]     = b;
        ifc.req_op_i[p]    = div_op_t'(op);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (ifc.resp_valid_o[p]) begin
                lat = c;
                break;
            end
        end
        data = ifc.resp_data_o[p];
        ifc.req_valid_i[p] = 1'b0;
        ifc.advance_i      = 1'b1;
        step();
        ifc.advance_i = 1'b0;
        valid_after   = ifc.resp_valid_o[p];
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        step();
        vectors++;
        if (ifc.resp_valid_o !== 2'b00) begin
            $display("FAIL reset_valid: got %b want 00", ifc.resp_valid_o);
            miscompares++;
        end
        vectors++;
        if (ifc.resp_data_o !== '0) begin
            $display("FAIL reset_data: got %h want 0", ifc.resp_data_o);
            miscompares++;
        end
        vectors++;
        if (ifc.stall_req_o !== 2'b00) begin
            $display("FAIL reset_stall: got %b want 00", ifc.stall_req_o);
            miscompares++;
        end
        ifc.req_valid_i = 2'b10;
        #1;
        vectors++;
        if (ifc.stall_req_o !== 2'b10) begin
            $display("FAIL stall_comb: got %b want 10", ifc.stall_req_o);
            miscompares++;
        end
        ifc.req_valid_i = 2'b00;
        step();
    endtask

    task automatic test_directed();
        logic [31:0] ta [12];
        logic [31:0] tb [12];
        logic [1:0]  top [12];
        logic [31:0] texp [12];
        int          lat;
        logic [31:0] data;
        logic        va;
        ta = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
               32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        tb = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        top = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
        texp = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        for (int i = 0; i < 12; i++) begin
            issue_and_wait(i % 2, ta[i], tb[i], top[i], lat, data, va);
            vectors++;
            if (lat != Lat) begin
                $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, Lat);
                miscompares++;
            end
            vectors++;
            if (data !== texp[i]) begin
                $display("FAIL dir_data[%0d]: got %h want %h", i, data, texp[i]);
                miscompares++;
            end
            vectors++;
            if (va !== 1'b0) begin
                $display("FAIL dir_slot_clear[%0d]: got %b want 0", i, va);
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [31:0] a, b, data;
        logic [1:0]  op;
        logic        va;
        int          p;
        for (int i = 0; i < 16; i++) begin
            p  = int'($urandom_range(1, 0));
            op = 2'($urandom_range(3, 0));
            a  = $urandom;
            case ($urandom_range(3, 0))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(15, 1));
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(3, 0));
                default: b = $urandom;
            endcase
            issue_and_wait(p, a, b, op, lat, data, va);
            vectors++;
            if (lat != Lat || data !== ref_div(a, b, op)) begin
                $display("FAIL rnd[%0d] p%0d %h/%h op%0d: got lat %0d data %h want lat %0d data %h",
                         i, p, a, b, op, lat, data, Lat, ref_div(a, b, op));
                miscompares++;
            end
        end
    endtask

    task automatic test_arbitration();
        int first0 = -1;
        int first1 = -1;
        ifc.req_a_i     = {32'd1000, 32'd77};
        ifc.req_b_i     = {32'd9, 32'd5};
        ifc.req_op_i    = '0;
        ifc.older_i     = 1'b1;
        ifc.req_valid_i = 2'b11;
        #1;
        vectors++;
        if (ifc.stall_req_o !== 2'b11) begin
            $display("FAIL arb_stall_start: got %b want 11", ifc.stall_req_o);
            miscompares++;
        end
        for (int c = 1; c <= 70; c++) begin
            step();
            if (first1 < 0 && ifc.resp_valid_o[1]) first1 = c;
            if (first0 < 0 && ifc.resp_valid_o[0]) first0 = c;
            if (c >= 35 && c <= 67) begin
                vectors++;
                if (ifc.stall_req_o !== 2'b01) begin
                    $display("FAIL arb_stall_mid@%0d: got %b want 01", c, ifc.stall_req_o);
                    miscompares++;
                end
            end else if (c >= 68) begin
                vectors++;
                if (ifc.stall_req_o !== 2'b00) begin
                    $display("FAIL arb_stall_end@%0d: got %b want 00", c, ifc.stall_req_o);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (first1 != 34 || first0 != 68) begin
            $display("FAIL arb_order: got p1@%0d p0@%0d want p1@34 p0@68", first1, first0);
            miscompares++;
        end
        vectors++;
        if (ifc.resp_data_o[1] !== 32'd111 || ifc.resp_data_o[0] !== 32'd15) begin
            $display("FAIL arb_data: got %h/%h want %h/%h", ifc.resp_data_o[1],
                     ifc.resp_data_o[0], 32'd111, 32'd15);
            miscompares++;
        end
        ifc.req_valid_i = 2'b00;
        ifc.advance_i   = 1'b1;
        step();
        ifc.advance_i = 1'b0;
        vectors++;
        if (ifc.resp_valid_o !== 2'b00) begin
            $display("FAIL arb_advance_clear: got %b want 00", ifc.resp_valid_o);
            miscompares++;
        end
    endtask

    task automatic test_flush();
        int   first1 = -1;
        logic saw0 = 1'b0;
        ifc.req_a_i     = {32'd500, 32'd123};
        ifc.req_b_i     = {32'd7, 32'd4};
        ifc.req_op_i    = '0;
        ifc.older_i     = 1'b0;
        ifc.req_valid_i = 2'b11;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (ifc.resp_valid_o[0]) saw0 = 1'b1;
            if (first1 < 0 && ifc.resp_valid_o[1]) first1 = c;
            ifc.clr_i = '0;
            if (c == 15) begin
                ifc.clr_i          = 2'b01;
                ifc.req_valid_i[0] = 1'b0;
            end
            // non-owner flush while pipe1 computes
            if (c == 20) ifc.clr_i = 2'b01;
        end
        vectors++;
        if (saw0 !== 1'b0) begin
            $display("FAIL flush_slot0: got valid 1 want 0");
            miscompares++;
        end
        vectors++;
        if (first1 != 50) begin
            $display("FAIL flush_p1_latency: got %0d want 50", first1);
            miscompares++;
        end
        vectors++;
        if (ifc.resp_data_o[1] !== 32'd71) begin
            $display("FAIL flush_p1_data: got %h want %h", ifc.resp_data_o[1], 32'd71);
            miscompares++;
        end
        ifc.req_valid_i = 2'b00;
        ifc.advance_i   = 1'b1;
        step();
        ifc.advance_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [31:0] data;
        logic        va;
        ifc.req_a_i[1]     = 32'd40;
        ifc.req_b_i[1]     = 32'd6;
        ifc.req_op_i[1]    = div_op_t'(2'd2);
        ifc.req_valid_i[1] = 1'b1;
        for (int c = 0; c < 40; c++) step();
        ifc.req_valid_i[1] = 1'b0;
        vectors++;
        if (ifc.resp_valid_o[1] !== 1'b1 || ifc.resp_data_o[1] !== 32'd4) begin
            $display("FAIL rstmid_pre: got %b/%h want 1/%h", ifc.resp_valid_o[1],
                     ifc.resp_data_o[1], 32'd4);
            miscompares++;
        end
        ifc.req_a_i[0]     = 32'd1000;
        ifc.req_b_i[0]     = 32'd3;
        ifc.req_op_i[0]    = div_op_t'(2'd0);
        ifc.req_valid_i[0] = 1'b1;
        for (int c = 0; c < 10; c++) step();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (ifc.resp_valid_o !== 2'b00) begin
            $display("FAIL rstmid_valid: got %b want 00", ifc.resp_valid_o);
            miscompares++;
        end
        vectors++;
        if (ifc.resp_data_o !== '0) begin
            $display("FAIL rstmid_data: got %h want 0", ifc.resp_data_o);
            miscompares++;
        end
        idle_inputs();
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        issue_and_wait(0, 32'd9, 32'd3, 2'd0, lat, data, va);
        vectors++;
        if (lat != Lat || data !== 32'd3) begin
            $display("FAIL rstmid_after: got lat %0d data %h want lat %0d data %h",
                     lat, data, Lat, 32'd3);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_arbitration();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_share_ctrl.md
DIV_SHARE_CTRL -- requirements
Module: div_share_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, meaning the number of iteration cycles (one quotient bit per cycle).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid_i, input, [1:0]: per-pipe divide request (pipe p = bit p); held high until the EX stage advances.
REQ-005 SHALL have port req_op_i, input, [1:0][1:0]: per pipe, bit0 = signed, bit1 = remainder (mod) result.
REQ-006 SHALL have ports req_a_i and req_b_i, input, [1:0][31:0] each: dividend and divisor.
REQ-007 SHALL have port older_i, input, 1 bit: index of the program-older pipe this cycle.
REQ-008 SHALL have port advance_i, input, 1 bit: the EX stage of both pipes advances this cycle.
REQ-009 SHALL have port clr_i, input, [1:0]: per-pipe EX flush.
REQ-010 SHALL have port stall_req_o, output, [1:0]: per-pipe stall request to the backend stall controller.
REQ-011 SHALL have port resp_valid_o, output, [1:0]: per-pipe result held in its slot.
REQ-012 SHALL have port resp_data_o, output, [1:0][31:0]: per-pipe slot result.

Function
REQ-013 SHALL contain one shared iterative divider, owned by at most one pipe at a time.
REQ-014 SHALL use FSM states IDLE -> CALC -> FIX -> IDLE.
REQ-015 In IDLE, SHALL accept pipe p when req_valid_i[p] & ~slot_valid[p] & ~clr_i[p] & ~advance_i.
REQ-016 If both pipes are eligible in IDLE, SHALL grant pipe older_i; the other pipe waits in IDLE.
REQ-017 On acceptance, SHALL latch operands as magnitudes, latch sign flags, op and owner, and enter CALC with the counter at 0.
REQ-018 CALC SHALL perform restoring division (one bit per cycle) for DIV_CYCLES cycles, then enter FIX.
REQ-019 FIX SHALL apply signs for signed ops, as follows:
- quotient is negated if the operand signs differ;
- remainder takes the sign of the dividend;
- then write the selected result into slot[owner], set slot_valid[owner], and return to IDLE.
REQ-020 Latency SHALL be: accept in cycle N, resp_valid_o[owner] high from cycle N+DIV_CYCLES+2.
REQ-021 Divide-by-zero SHALL give quotient 0xFFFFFFFF and remainder equal to the dividend (unsigned and signed alike).
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-023 stall_req_o[p] SHALL equal req_valid_i[p] & ~slot_valid[p] (combinational).
REQ-024 resp_valid_o and resp_data_o SHALL be driven from registers only.
REQ-025 A slot SHALL hold its result until advance_i or clr_i[p]; either clears slot_valid[p] on the next edge.
REQ-026 Slot clear on advance_i or clr_i SHALL take priority over a same-cycle FIX write, for both pipes.
REQ-027 clr_i[owner] during CALC or FIX SHALL abort to IDLE on the next edge and write no slot.
REQ-028 After an abort, the other pipe SHALL be eligible from the following cycle.
REQ-029 clr_i of the non-owner pipe SHALL leave the in-flight operation untouched.
REQ-030 advance_i while the FSM is busy SHALL abort the operation; this is legal only when stall_req_o is 0 for the owner, which does not occur.
REQ-031 A bench assertion SHALL flag advance_i while the FSM is busy.

Reset
REQ-032 rst_n low SHALL asynchronously set:
- FSM to IDLE and counter to 0;
- owner to 0 and slot_valid to 0;
- resp_data_o to 0 and resp_valid_o to 0.
REQ-033 Reset asserted mid-CALC SHALL discard the operation; the first post-reset request behaves as from power-up.

Structure
REQ-034 The div_op_t typedef and DIV_CYCLES default SHALL live in the shared pipeline package.
REQ-035 The FSM state enum SHALL be local to the module.
REQ-036 The iterative datapath SHALL be a sub-module div_iter, covering shift/subtract, counter and done pulse.
REQ-037 div_share_ctrl SHALL hold arbitration, sign handling, slots and flush logic.

Verification
REQ-038 Unsigned 100/7 on pipe0, accepted at cycle 10: resp_valid_o[0]=1 from cycle 44 with data 14; repeat with mod: data 2.
REQ-039 Signed -7/2 (0xFFFFFFF9/2): quotient 0xFFFFFFFD; mod gives 0xFFFFFFFF.
REQ-040 Both pipes request at cycle 0 with older_i=1: pipe1 valid at 34, pipe0 valid at 68; stall_req_o=2'b01 during 35..67, 2'b00 from 68.
REQ-041 Divide-by-zero 5/0 unsigned gives 0xFFFFFFFF and mod gives 5; signed 0x80000000/-1 gives 0x80000000, mod gives 0.
REQ-042 clr_i[0] at cycle 15 of a pipe0 op with a pending pipe1 request: pipe0 slot stays empty; pipe1 accepted at cycle 16, valid at 50.
REQ-043 rst_n pulsed low mid-CALC: outputs 0 immediately; a new 9/3 request afterwards returns 3 at N+34.
